// File: rtl/change_dispenser.sv
// Greedy change payout: converts a BCD amount into a sequence of one-hot coin requests.
// Each coin is handed over by request/ack; aborts on a missing ack or an illegal amount.
module change_dispenser #(
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] change_i,
  input  logic       coin_ack_i,
  output logic [2:0] coin_o,
  output logic [7:0] remaining_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o
);

  typedef enum logic [2:0] {StIdle, StCheck, StPresent, StGap, StFinish} state_e;

  localparam logic [2:0] CoinQuarter = 3'd4;
  localparam logic [2:0] CoinDime    = 3'd2;
  localparam logic [2:0] CoinNickel  = 3'd1;

  state_e      state_q;
  logic [2:0]  coin_q;
  logic [7:0]  rem_q;
  logic        busy_q, done_q, error_q;
  logic [15:0] tmo_q, gap_q;

  logic       illegal;
  logic [2:0] coin_sel;
  logic [7:0] rem_paid;

  // BCD subtract of a coin value; amounts are always multiples of 5 so units are 0 or 5.
  function automatic logic [7:0] bcd_sub(input logic [7:0] a, input logic [2:0] c);
    logic [3:0] st, su, nu, nt;
    logic       borrow;
    case (c)
      CoinQuarter: begin st = 4'd2; su = 4'd5; end
      CoinDime:    begin st = 4'd1; su = 4'd0; end
      default:     begin st = 4'd0; su = 4'd5; end
    endcase
    if (a[3:0] >= su) begin
      nu     = a[3:0] - su;
      borrow = 1'b0;
    end else begin
      nu     = a[3:0] + 4'd10 - su;
      borrow = 1'b1;
    end
    nt = a[7:4] - st - {3'b000, borrow};
    return {nt, nu};
  endfunction

  always_comb begin
    illegal  = (rem_q[7:4] > 4'd9) || !((rem_q[3:0] == 4'd0) || (rem_q[3:0] == 4'd5));
    rem_paid = bcd_sub(rem_q, coin_q);
    if ((rem_q[7:4] > 4'd2) || ((rem_q[7:4] == 4'd2) && (rem_q[3:0] >= 4'd5))) begin
      coin_sel = CoinQuarter;
    end else if (rem_q[7:4] >= 4'd1) begin
      coin_sel = CoinDime;
    end else begin
      coin_sel = CoinNickel;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      coin_q  <= 3'd0;
      rem_q   <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      tmo_q   <= 16'd0;
      gap_q   <= 16'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            rem_q   <= change_i;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (illegal) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            rem_q   <= 8'h00;
            state_q <= StIdle;
          end else if (rem_q == 8'h00) begin
            done_q  <= 1'b1;
            state_q <= StFinish;
          end else begin
            coin_q  <= coin_sel;
            tmo_q   <= 16'd0;
            state_q <= StPresent;
          end
        end
        StPresent: begin
          if (coin_ack_i) begin
            rem_q   <= rem_paid;
            coin_q  <= 3'd0;
            tmo_q   <= 16'd0;
            gap_q   <= 16'd0;
            state_q <= StGap;
          end else if (tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
            // Abort keeps the unpaid amount visible for the caller.
            coin_q  <= 3'd0;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            tmo_q   <= 16'd0;
            state_q <= StIdle;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        StGap: begin
          if (gap_q == 16'(GAP_CYCLES - 1)) begin
            gap_q   <= 16'd0;
            state_q <= StCheck;
          end else begin
            gap_q <= gap_q + 16'd1;
          end
        end
        StFinish: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign coin_o      = coin_q;
  assign remaining_o = rem_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy model queues the expected coins and
// post-ack amounts; a monitor pops and compares them as the DUT issues requests.
module tb_change_dispenser;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] change = 8'h00;
  logic       coin_ack = 1'b0;
  logic [2:0] coin;
  logic [7:0] remaining;
  logic       busy, done, error;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0] coin;
    logic [7:0] rem;
  } exp_t;
  exp_t exp_q[$];

  logic       ack_en = 1'b1;
  logic [2:0] prev_coin = 3'd0;
  logic [7:0] pend_rem = 8'h00;

  change_dispenser #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(8)) dut (
    .clock_i    (clock),
    .reset_i    (reset),
    .start_i    (start),
    .change_i   (change),
    .coin_ack_i (coin_ack),
    .coin_o     (coin),
    .remaining_o(remaining),
    .busy_o     (busy),
    .done_o     (done),
    .error_o    (error)
  );

  always #5 clock = ~clock;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  // Independent greedy model in binary arithmetic.
  function automatic void push_exp(input logic [7:0] c);
    int v;
    v = int'(c[7:4]) * 10 + int'(c[3:0]);
    while (v >= 25) begin v -= 25; exp_q.push_back('{3'd4, to_bcd(v)}); end
    while (v >= 10) begin v -= 10; exp_q.push_back('{3'd2, to_bcd(v)}); end
    while (v >= 5)  begin v -= 5;  exp_q.push_back('{3'd1, to_bcd(v)}); end
  endfunction

  task automatic pulse_start(input logic [7:0] c);
    @(posedge clock); #1;
    start  = 1'b1;
    change = c;
    @(posedge clock); #1;
    start  = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done) begin seen = 1'b1; break; end
    end
    chk_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk_eq({tag, "_rem_zero"}, 32'(remaining), 32'h00);
      chk_eq({tag, "_error"}, 32'(error), 32'd0);
      @(negedge clock);
      chk_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk_eq({tag, "_busy_low"}, 32'(busy), 32'd0);
    end
    chk_eq({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Mechanism model: acknowledges each request 3 cycles after it appears.
  initial forever begin
    @(negedge clock);
    if (ack_en && coin != 3'd0) begin
      repeat (2) @(negedge clock);
      coin_ack = 1'b1;
      @(negedge clock);
      coin_ack = 1'b0;
    end
  end

  always @(negedge clock) begin
    if (coin != 3'd0 && prev_coin == 3'd0) begin
      if (exp_q.size() == 0) begin
        chk_eq("unexpected_coin", 32'(coin), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk_eq("coin_code", 32'(coin), 32'(e.coin));
        pend_rem = e.rem;
      end
    end else if (coin != 3'd0) begin
      chk_eq("coin_stable", 32'(coin), 32'(prev_coin));
    end else if (prev_coin != 3'd0 && busy) begin
      chk_eq("rem_after_ack", 32'(remaining), 32'(pend_rem));
    end
    prev_coin = coin;
  end

  initial begin
    bit   got;
    int   held;
    #12;
    chk_eq("rst_coin", 32'(coin), 32'd0);
    chk_eq("rst_rem", 32'(remaining), 32'h00);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_done", 32'(done), 32'd0);
    chk_eq("rst_error", 32'(error), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // 40 -> quarter, dime, nickel
    push_exp(8'h40);
    pulse_start(8'h40);
    wait_done(200, "c40");

    // 20 -> dime, dime
    push_exp(8'h20);
    pulse_start(8'h20);
    wait_done(200, "c20");

    // 00 -> done two cycles after start, busy exactly two cycles
    pulse_start(8'h00);
    @(negedge clock);
    chk_eq("z_busy1", 32'(busy), 32'd1);
    chk_eq("z_done1", 32'(done), 32'd0);
    @(negedge clock);
    chk_eq("z_busy2", 32'(busy), 32'd1);
    chk_eq("z_done2", 32'(done), 32'd1);
    @(negedge clock);
    chk_eq("z_busy3", 32'(busy), 32'd0);
    chk_eq("z_done3", 32'(done), 32'd0);

    // illegal amounts
    pulse_start(8'h17);
    @(negedge clock);
    chk_eq("i17_busy_check", 32'(busy), 32'd1);
    @(negedge clock);
    chk_eq("i17_error", 32'(error), 32'd1);
    chk_eq("i17_busy", 32'(busy), 32'd0);
    chk_eq("i17_rem", 32'(remaining), 32'h00);
    chk_eq("i17_done", 32'(done), 32'd0);
    pulse_start(8'hA0);
    repeat (2) @(negedge clock);
    chk_eq("iA0_error", 32'(error), 32'd1);
    chk_eq("iA0_busy", 32'(busy), 32'd0);
    chk_eq("iA0_done", 32'(done), 32'd0);
    push_exp(8'h05);
    pulse_start(8'h05);
    @(negedge clock);
    chk_eq("err_cleared", 32'(error), 32'd0);
    wait_done(100, "c05");

    // timeout on 35
    ack_en = 1'b0;
    push_exp(8'h35);
    pulse_start(8'h35);
    held = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (coin == 3'd4) held++;
    end
    chk_eq("tmo_held", 32'(held), 32'd8);
    chk_eq("tmo_coin", 32'(coin), 32'd0);
    chk_eq("tmo_error", 32'(error), 32'd1);
    chk_eq("tmo_rem", 32'(remaining), 32'h35);
    chk_eq("tmo_busy", 32'(busy), 32'd0);
    exp_q.delete();
    ack_en = 1'b1;

    // 95 with a stray start in GAP and a reset during the second quarter
    push_exp(8'h95);
    pulse_start(8'h95);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (coin != 3'd0) begin got = 1'b1; break; end
    end
    chk_eq("r_first_coin", 32'(got), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (coin == 3'd0) begin got = 1'b1; break; end
    end
    chk_eq("r_first_ack", 32'(got), 32'd1);
    pulse_start(8'h05);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (coin != 3'd0) begin got = 1'b1; break; end
    end
    chk_eq("r_second_coin", 32'(got), 32'd1);
    chk_eq("r_stray_ignored", 32'(remaining), 32'h70);
    #2;
    reset = 1'b1;
    #1;
    chk_eq("r_coin", 32'(coin), 32'd0);
    chk_eq("r_rem", 32'(remaining), 32'h00);
    chk_eq("r_busy", 32'(busy), 32'd0);
    chk_eq("r_done", 32'(done), 32'd0);
    chk_eq("r_error", 32'(error), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clock);

    push_exp(8'h10);
    pulse_start(8'h10);
    @(negedge clock);
    chk_eq("post_rst_busy", 32'(busy), 32'd1);
    wait_done(100, "c10");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Pays out change after a vend. It accepts a BCD change amount and emits a sequence of single-coin requests to the coin-return mechanism. Coins are chosen greedily: quarter first, then dime, then nickel. Coin codes use the same 3-bit one-hot encoding as the vendor's coin inputs: quarter = 3'd4, dime = 3'd2, nickel = 3'd1. Each coin is handed over with a request/acknowledge handshake; the block reports the unpaid amount and a completion pulse.

Parameters:
GAP_CYCLES, 4, idle clock cycles with coin = 0 between an acknowledged coin and the next request (minimum 1).
TIMEOUT_CYCLES, 1000, maximum cycles a coin request is held without coin_ack before aborting (counter 16 bits wide).

Ports:
clock  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  single-cycle strobe; samples change.
change  input  8  BCD amount, [7:4] tens and [3:0] units; legal values 00..95 with units 0 or 5.
coin_ack  input  1  mechanism acknowledge; the coin is taken on the first clock edge where coin_ack = 1 while coin != 0.
coin  output  3  current coin request (one-hot); 3'b000 when no request.
remaining  output  8  BCD amount still owed.
busy  output  1  high from the accepted start until the return to IDLE.
done  output  1  one-cycle pulse when the full amount has been paid.
error  output  1  sticky error flag; cleared by the next accepted start or by reset.

Behaviour:
- Reset (asynchronous, any state): state = IDLE; coin = 0, remaining = 8'h00, busy = 0, done = 0, error = 0; gap and timeout counters = 0.
- States: IDLE, CHECK, PRESENT, GAP, FINISH.
- IDLE:
  - start = 1 at edge N → remaining = change, error = 0, busy = 1, state = CHECK after edge N.
  - start while busy = 1 is ignored.
- CHECK (one cycle), evaluated in order:
  - Illegal input (tens > 9, or units not 0 and not 5): error = 1, busy = 0, remaining = 00, no coins issued, back to IDLE.
  - remaining = 00: go to FINISH.
  - Otherwise go to PRESENT, with coin loaded at edge N+1 as follows:
    - quarter if remaining >= 25;
    - else dime if remaining >= 10;
    - else nickel.
- PRESENT:
  - coin held stable; timeout counter increments each cycle.
  - coin_ack = 1 → remaining reduced by the coin value using BCD subtraction (units borrow from tens; result always a multiple of 5); coin = 0; timeout counter cleared; go to GAP.
  - Counter reaches TIMEOUT_CYCLES without an ack → coin = 0, error = 1, busy = 0, remaining keeps the unpaid amount, go to IDLE (abort).
- GAP:
  - Counts GAP_CYCLES cycles, then goes to CHECK (re-selects a coin or finishes).
  - coin_ack is ignored while coin = 0.
- FINISH: done = 1 for exactly one cycle, busy = 0, go to IDLE; remaining stays 00.
- Latency:
  - First coin is visible 2 cycles after the start edge.
  - Per-coin period = (ack wait) + 1 + GAP_CYCLES + 1 cycles.
  - start with change = 00 → done pulse 2 cycles after start, no coins.
- coin_ack held high continuously: each coin is still counted once, since the gap forces coin = 0 between requests.
- Reset mid-payout drops the request immediately; the owed amount is lost and is not retried.
- Worst case payout: 95 = 3 quarters + 2 dimes.

Test Plan:
- start with change = 8'h40, coin_ack returned 3 cycles after each request → coin sequence 4, 2, 1; remaining goes 40 → 15 → 05 → 00; single done pulse; error = 0.
- start with change = 8'h20 → dime, dime (no quarter, no nickel); done after the second ack.
- start with change = 8'h00 → no coin ever nonzero; done 2 cycles after start; busy high for exactly 2 cycles.
- start with change = 8'h17, then separately 8'hA0 → error = 1, coin never nonzero, no done, busy drops after CHECK; a following legal start clears error.
- start with change = 8'h35, no ack for TIMEOUT_CYCLES (bench run with TIMEOUT_CYCLES = 8) → quarter held 8 cycles, then coin = 0, error = 1, remaining = 35, busy = 0.
- start with 8'h95, assert reset during the second quarter's PRESENT; also pulse start during GAP → the extra start is ignored; reset gives all outputs 0 immediately and IDLE accepts the next start normally.
